// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline memory-port arbiter.
package pipe_pkg;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

endpackage

// File: rtl/arb_prio_streak.sv
// Data-priority grant logic with a bounded data streak so a waiting fetch
// cannot be starved for more than DATA_STREAK_MAX consecutive data grants.
module arb_prio_streak #(
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic if_req_valid,
    input  logic if_kill,
    input  logic ls_req_valid,
    output logic grant_if,
    output logic grant_ls
);

    localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

    logic [3:0] ds_cnt;
    logic       fetch_ok;
    logic       at_max;

    always_comb begin
        fetch_ok = if_req_valid & ~if_kill;
        at_max   = (ds_cnt == STREAK_MAX);
        grant_ls = arb_en & ls_req_valid & ~(fetch_ok & at_max);
        grant_if = arb_en & fetch_ok & (~ls_req_valid | at_max);
    end

    // The streak only grows while a live fetch is actually being passed over.
    always_ff @(posedge clk) begin
        if (rst) begin
            ds_cnt <= 4'd0;
        end else if (grant_if) begin
            ds_cnt <= 4'd0;
        end else if (grant_ls) begin
            if (!fetch_ok)
                ds_cnt <= 4'd0;
            else if (!at_max)
                ds_cnt <= ds_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// outstanding transaction at a time: arbitrate (IDLE), issue (ISSUE), wait (WAIT).
module mem_port_arbiter #(
    parameter int ADDR_W          = pipe_pkg::ADDR_W,
    parameter int DATA_W          = pipe_pkg::DATA_W,
    parameter int INSTR_W         = pipe_pkg::INSTR_W,
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req_valid,
    output logic               if_req_ready,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic               if_rsp_valid,
    output logic [INSTR_W-1:0] if_rsp_instr,
    input  logic               if_kill,
    input  logic               ls_req_valid,
    output logic               ls_req_ready,
    input  logic [ADDR_W-1:0]  ls_addr,
    input  logic               ls_wen,
    input  logic [DATA_W-1:0]  ls_wdata,
    input  logic [3:0]         ls_wlen,
    output logic               ls_rsp_valid,
    output logic [DATA_W-1:0]  ls_rsp_rdata,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wen,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [3:0]         mem_wlen,
    input  logic               mem_rsp_valid,
    input  logic [DATA_W-1:0]  mem_rsp_rdata
);

    import pipe_pkg::*;

    state_t              state_q, state_d;
    owner_t              owner_q;
    logic                kill_q;
    logic                half_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          wlen_q;
    logic                grant_if, grant_ls;
    logic                arb_en;
    logic                done;

    assign arb_en = (state_q == IDLE);
    assign done   = (state_q == WAIT) & mem_rsp_valid;

    arb_prio_streak #(
        .DATA_STREAK_MAX (DATA_STREAK_MAX)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .arb_en       (arb_en),
        .if_req_valid (if_req_valid),
        .if_kill      (if_kill),
        .ls_req_valid (ls_req_valid),
        .grant_if     (grant_if),
        .grant_ls     (grant_ls)
    );

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign mem_req_valid = (state_q == ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wlen      = wlen_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_if | grant_ls) state_d = ISSUE;
            ISSUE:   if (mem_req_ready)       state_d = WAIT;
            WAIT:    if (mem_rsp_valid)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request buffer, ownership, kill tracking and registered responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OWN_IF;
            kill_q       <= 1'b0;
            half_q       <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wlen_q       <= 4'd0;
            if_rsp_valid <= 1'b0;
            if_rsp_instr <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_rdata <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;

            if (grant_ls) begin
                owner_q <= OWN_LS;
                addr_q  <= ls_addr;
                wen_q   <= ls_wen;
                wdata_q <= ls_wdata;
                wlen_q  <= ls_wlen;
                half_q  <= ls_addr[2];
            end else if (grant_if) begin
                owner_q <= OWN_IF;
                addr_q  <= if_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wlen_q  <= 4'd0;
                half_q  <= if_addr[2];
            end

            // A killed fetch still drains from memory; only its response is dropped.
            if (done) begin
                kill_q <= 1'b0;
                if (owner_q == OWN_IF) begin
                    if (!(kill_q | if_kill)) begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_instr <= half_q ? mem_rsp_rdata[2*INSTR_W-1:INSTR_W]
                                               : mem_rsp_rdata[INSTR_W-1:0];
                    end
                end else begin
                    ls_rsp_valid <= 1'b1;
                    ls_rsp_rdata <= wen_q ? '0 : mem_rsp_rdata;
                end
            end else if (state_q != IDLE && owner_q == OWN_IF && if_kill) begin
                kill_q <= 1'b1;
            end
        end
    end

endmodule
